uart_tx: RTL
============

# uart_tx

Parameterised UART transmitter: the transmit counterpart of the board's UART receiver, sharing the same parameter set and frame format. It accepts a data word over a valid/ready handshake and serialises it on `o_uart_tx`. The frame is 1 start bit, DATA_WIDTH data bits LSB-first, an optional parity bit, then 1 stop bit. It sits between the photo-frame control logic and the board TX pin, and loops back to the receiver for self-test.

## Interface
- CLK_FRE, 50: system clock in MHz.
- DATA_WIDTH, 8: data bits per frame. Legal range 5..9.
- PARITY_ON, 0: 1 inserts a parity bit; 0 means no parity bit.
- PARITY_TYPE, 0: 1 selects odd parity, 0 selects even parity.
- BAUD_RATE, 9600: line rate in bit/s.

Ports (reset i_rst_n, asynchronous, active-low; clock i_clk_sys):
- i_clk_sys  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_tx_valid  in  1  upstream offers `i_tx_data`
- i_tx_data  in  DATA_WIDTH  word to send
- o_tx_ready  out  1  block can accept a word this cycle
- o_uart_tx  out  1  serial line; idles high
- o_tx_done  out  1  one-cycle pulse when the stop bit completes
- o_state  out  3  current FSM state, for debug

## Operation
- Bit period CYCLE = CLK_FRE*1000000/BAUD_RATE clocks, using integer division. Default is 5208.
- Elaboration must fail unless 2 ≤ CYCLE ≤ 65535.
- Baud counter is 16 bits and counts 0..CYCLE-1 within each state. It reloads to 0 on every state change.
- States use the receiver's encoding: IDLE=000, START=001, DATA=011, PARITY=100, END=101.
- IDLE: `o_uart_tx`=1 and `o_tx_ready`=1. On an edge with `i_tx_valid`=1:
  - latch `i_tx_data` into the shift register;
  - latch parity = (^i_tx_data) XOR PARITY_TYPE;
  - go to START, drive `o_uart_tx`←0, `o_tx_ready`←0.
- START: at baud count CYCLE-1, go to DATA and drive `o_uart_tx`←shift[0].
- DATA: at baud count CYCLE-1:
  - if bit count = DATA_WIDTH-1, go to PARITY (`o_uart_tx`←parity) when PARITY_ON=1, otherwise go to END (`o_uart_tx`←1);
  - else shift right, increment the 4-bit bit count, and drive `o_uart_tx`←next bit.
- PARITY: at baud count CYCLE-1, go to END and drive `o_uart_tx`←1.
- END: at baud count CYCLE-1, go to IDLE. Assert `o_tx_ready`←1 and pulse `o_tx_done`←1 for 1 cycle.
- Parity rule: the number of ones in data plus the parity bit, mod 2, equals PARITY_TYPE. This matches the receiver's check exactly.
- Busy rules:
  - `i_tx_valid` is ignored outside IDLE.
  - `i_tx_data` changes after acceptance have no effect on the frame.
  - Upstream holds the word until it sees valid&ready.
- Reset values: `o_uart_tx`=1, `o_tx_ready`=1, `o_tx_done`=0, `o_state`=000.
- Reset asserted mid-frame: the line goes high immediately (asynchronous). The frame is discarded, no `o_tx_done` is produced, and the block restarts in IDLE.

## Timing
- All outputs are registered.
- Acceptance at edge 0 drives the line low from edge 0.
- Each bit is exactly CYCLE clocks.
- Frame length N = (2 + DATA_WIDTH + PARITY_ON)·CYCLE clocks.
- `o_tx_done` and `o_tx_ready` rise at edge N.
- With `i_tx_valid` held high, the next acceptance is at edge N+1. The stop bit therefore lasts CYCLE+1 clocks back-to-back; the minimum inter-frame period is N+1.
- `o_state` tracks the state register with 0 cycles of extra delay.

## Structure
- Shared package `uart_pkg` holds:
  - state localparams (also used by the receiver);
  - a `calc_cycle(CLK_FRE, BAUD_RATE)` function;
  - a parity function `calc_parity(data, type)`.
- One natural sub-module: `uart_baud_cnt`.
  - Parameter CYCLE; inputs enable and clear; outputs the 16-bit count and `o_bit_end` (count = CYCLE-1).
  - Reusable by the receiver.
- FSM and shift register stay in `uart_tx`.

## Test plan
Bench parameters: CLK_FRE=1, BAUD_RATE=100000, giving CYCLE=10.
- Reset: release `i_rst_n` -> `o_uart_tx`=1, `o_tx_ready`=1, `o_tx_done`=0, `o_state`=000; line stays high with no valid.
- Send 0x55 with PARITY_ON=0 -> line low for 10 clocks, then 1,0,1,0,1,0,1,0 at 10 clocks each, then high. `o_tx_done` pulses at edge 100, `o_tx_ready` is low on edges 0..99.
- Send 0x07 with PARITY_ON=1:
  - PARITY_TYPE=0 -> parity bit = 1;
  - PARITY_TYPE=1 -> parity bit = 0;
  - `o_tx_done` at edge 110 in both cases.
- Valid held, 0xA3 then 0x3C -> second start bit begins at edge 101, stop high is 11 clocks, and both words are decoded correctly on the line.
- Drive valid plus 0xFF during DATA of a 0x00 frame -> ignored, and the line carries 0x00. Reset asserted in data bit 3 -> line high immediately, no done pulse, and the next frame after release is correct.
- Loopback into the receiver with matching parameters: 0x00, 0xFF and 256 random words -> each `o_rx_done` carries the same `o_uart_data`, with `o_ld_parity`=1 when parity is enabled.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and helpers for both the
// transmitter and the receiver.
package uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_START  = 3'b001;
  localparam logic [2:0] S_DATA   = 3'b011;
  localparam logic [2:0] S_PARITY = 3'b100;
  localparam logic [2:0] S_END    = 3'b101;

  // Clocks per bit, truncating integer division.
  function automatic int calc_cycle(input int clk_fre, input int baud_rate);
    return (clk_fre * 1000000) / baud_rate;
  endfunction

  // Parity bit such that popcount(data) + parity is congruent to ptype mod 2.
  // Narrower words are zero-extended, so the extra bits do not change the result.
  function automatic logic calc_parity(input logic [8:0] data, input logic ptype);
    return (^data) ^ ptype;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CYCLE-1 while enabled and flags the last
// clock of each bit.
module uart_baud_cnt #(
  parameter int CYCLE = 5208
) (
  input  logic        i_clk_sys,
  input  logic        i_rst_n,
  input  logic        enable,
  input  logic        clear,
  output logic [15:0] count,
  output logic        o_bit_end
);

  localparam logic [15:0] LAST = 16'(CYCLE - 1);

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n)    count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 16'd1;
  end

  assign o_bit_end = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB-first, optional parity,
// one stop bit. Word accepted on valid&ready while idle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FRE     = 50,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_ON   = 0,
  parameter int PARITY_TYPE = 0,
  parameter int BAUD_RATE   = 9600
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst_n,
  input  logic                  i_tx_valid,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  output logic                  o_tx_ready,
  output logic                  o_uart_tx,
  output logic                  o_tx_done,
  output logic [2:0]            o_state
);

  localparam int CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);

  if (CYCLE < 2 || CYCLE > 65535) begin : g_bad_cycle
    $error("uart_tx: CLK_FRE/BAUD_RATE gives a bit period outside 2..65535");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx: DATA_WIDTH must be 5..9");
  end

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par;
  logic [3:0]            bit_cnt;
  logic                  bit_end;
  // The count itself serves the receiver's mid-bit sampling; TX only needs bit_end.
  logic [15:0]           baud_cnt_unused;

  // Every state change out of a busy state happens on bit_end, so clearing on
  // bit_end (and holding zero while idle) restarts the count on each new state.
  uart_baud_cnt #(.CYCLE(CYCLE)) u_baud (
    .i_clk_sys (i_clk_sys),
    .i_rst_n   (i_rst_n),
    .enable    (state != S_IDLE),
    .clear     (bit_end || state == S_IDLE),
    .count     (baud_cnt_unused),
    .o_bit_end (bit_end)
  );

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      shift      <= '0;
      par        <= 1'b0;
      bit_cnt    <= '0;
      o_uart_tx  <= 1'b1;
      o_tx_ready <= 1'b1;
      o_tx_done  <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      case (state)
        S_IDLE: if (i_tx_valid) begin
          shift      <= i_tx_data;
          par        <= calc_parity(9'(i_tx_data), 1'(PARITY_TYPE));
          bit_cnt    <= '0;
          state      <= S_START;
          o_uart_tx  <= 1'b0;
          o_tx_ready <= 1'b0;
        end
        S_START: if (bit_end) begin
          state     <= S_DATA;
          o_uart_tx <= shift[0];
        end
        S_DATA: if (bit_end) begin
          if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
            if (PARITY_ON != 0) begin
              state     <= S_PARITY;
              o_uart_tx <= par;
            end else begin
              state     <= S_END;
              o_uart_tx <= 1'b1;
            end
          end else begin
            shift     <= shift >> 1;
            bit_cnt   <= bit_cnt + 4'd1;
            o_uart_tx <= shift[1];
          end
        end
        S_PARITY: if (bit_end) begin
          state     <= S_END;
          o_uart_tx <= 1'b1;
        end
        S_END: if (bit_end) begin
          state      <= S_IDLE;
          o_tx_ready <= 1'b1;
          o_tx_done  <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          o_uart_tx  <= 1'b1;
          o_tx_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_state = state;

endmodule
